// File: rtl/lr_pkg.sv
// Shared types and defaults for the linear-regression coefficient control path.
package lr_pkg;

    localparam int LR_N_SAMPLES = 150;
    localparam int LR_ADDR_W    = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_P1,
        S_P1_DRN,
        S_MEAN_X,
        S_MEAN_Y,
        S_P2,
        S_P2_DRN,
        S_SLOPE,
        S_ICPT,
        S_DONE
    } lr_state_e;

    typedef enum logic [1:0] {
        DIV_XMEAN = 2'd0,
        DIV_YMEAN = 2'd1,
        DIV_SLOPE = 2'd2
    } lr_div_sel_e;

    // States that own the shared divider.
    function automatic logic is_div_state(input lr_state_e s);
        return (s == S_MEAN_X) || (s == S_MEAN_Y) || (s == S_SLOPE);
    endfunction

endpackage

// File: rtl/lr_sample_counter.sv
// Sample address counter shared by both passes; wraps to 0 after the last sample.
module lr_sample_counter #(
    parameter int N_SAMPLES = 150,
    parameter int ADDR_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == ADDR_W'(N_SAMPLES - 1));
    assign cnt_o  = cnt_q;

    // Next count: clear wins, otherwise step and wrap at the last sample.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lr_coeff_sequencer.sv
// Control FSM for the regression datapath: two sample passes, three shared
// divides (x-mean, y-mean, slope) and the final intercept load.
module lr_coeff_sequencer
    import lr_pkg::*;
#(
    parameter int N_SAMPLES = LR_N_SAMPLES,
    parameter int ADDR_W    = LR_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              mem_rd_o,
    output logic              acc_clr_o,
    output logic              acc1_en_o,
    output logic              acc2_en_o,
    output logic              div_start_o,
    output logic [1:0]        div_sel_o,
    input  logic              div_done_i,
    output logic              xm_ld_o,
    output logic              ym_ld_o,
    output logic              b1_ld_o,
    output logic              b0_ld_o,
    output logic              busy_o,
    output logic              coeff_done_o
);

    lr_state_e state_q, state_d;
    logic      first_q, first_d;   // first cycle of the current state
    logic      acc1_q, acc2_q;     // read strobe delayed to match memory latency
    logic      cnt_clr, cnt_inc, cnt_last;
    logic      div_ack;

    lr_sample_counter #(
        .N_SAMPLES (N_SAMPLES),
        .ADDR_W    (ADDR_W)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (addr_o),
        .last_o (cnt_last)
    );

    // A done pulse only counts after the launch cycle of a divide state.
    assign div_ack = is_div_state(state_q) && !first_q && div_done_i;
    assign first_d = (state_d != state_q);

    // Next-state logic and counter control.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            S_IDLE:   if (en_i) state_d = S_CLR;
            S_CLR: begin
                cnt_clr = 1'b1;
                state_d = S_P1;
            end
            S_P1: begin
                cnt_inc = 1'b1;
                if (cnt_last) state_d = S_P1_DRN;
            end
            S_P1_DRN: state_d = S_MEAN_X;
            S_MEAN_X: if (div_ack) state_d = S_MEAN_Y;
            S_MEAN_Y: if (div_ack) state_d = S_P2;
            S_P2: begin
                cnt_inc = 1'b1;
                if (cnt_last) state_d = S_P2_DRN;
            end
            S_P2_DRN: state_d = S_SLOPE;
            S_SLOPE:  if (div_ack) state_d = S_ICPT;
            S_ICPT:   state_d = S_DONE;
            S_DONE:   if (en_i) state_d = S_CLR;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state; loads qualify on the divider ack.
    always_comb begin
        mem_rd_o     = (state_q == S_P1) || (state_q == S_P2);
        acc_clr_o    = (state_q == S_CLR);
        div_start_o  = is_div_state(state_q) && first_q;
        xm_ld_o      = (state_q == S_MEAN_X) && div_ack;
        ym_ld_o      = (state_q == S_MEAN_Y) && div_ack;
        b1_ld_o      = (state_q == S_SLOPE)  && div_ack;
        b0_ld_o      = (state_q == S_ICPT);
        busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
        coeff_done_o = (state_q == S_DONE);
        case (state_q)
            S_MEAN_Y: div_sel_o = DIV_YMEAN;
            S_SLOPE:  div_sel_o = DIV_SLOPE;
            default:  div_sel_o = DIV_XMEAN;
        endcase
    end

    assign acc1_en_o = acc1_q;
    assign acc2_en_o = acc2_q;

    // State, first-cycle flag and accumulate-enable delay registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            acc1_q  <= 1'b0;
            acc2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            acc1_q  <= (state_q == S_P1);
            acc2_q  <= (state_q == S_P2);
        end
    end

endmodule

// File: doc/lr_coeff_sequencer.md
# lr_coeff_sequencer

Control FSM for the linear-regression coefficient datapath. It walks the x/y sample memories in two passes: pass 1 accumulates sums and pass 2 accumulates deviation products. It schedules the single shared divider for x-mean, y-mean and slope, then loads b0. It owns the sample address counter and raises `coeff_done` when b1/b0 are valid. It sits between the top-level start logic and the coefficient datapath (accumulators, divider, b0/b1 registers).

## Interface
- `N_SAMPLES`, 150, samples per run; legal range 2..2^ADDR_W
- `ADDR_W`, 8, sample memory address width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  start request, sampled in IDLE/DONE
- `addr`  out  ADDR_W  sample memory address
- `mem_rd`  out  1  memory read strobe; synchronous memory, data valid next cycle
- `acc_clr`  out  1  clear all datapath accumulators
- `acc1_en`  out  1  pass-1 accumulate (Σx, Σy)
- `acc2_en`  out  1  pass-2 accumulate (Σ(x-x̄)(y-ȳ), Σ(x-x̄)²)
- `div_start`  out  1  one-cycle divider launch
- `div_sel`  out  2  divider operand select: 0 = Σx/N, 1 = Σy/N, 2 = Sxy/Sxx; held for the whole divide
- `div_done`  in  1  divider result valid, one-cycle pulse
- `xm_ld`, `ym_ld`, `b1_ld`, `b0_ld`  out  1 each  register loads
- `busy`  out  1  high in every state except IDLE/DONE
- `coeff_done`  out  1  level; b0/b1 valid

## Operation
- States: IDLE → CLR → P1 → P1_DRN → MEAN_X → MEAN_Y → P2 → P2_DRN → SLOPE → ICPT → DONE.
- IDLE: all outputs 0; `en`=1 → CLR.
- CLR (1 cycle): `acc_clr`=1; address counter cleared to 0.
- P1 (N_SAMPLES cycles): `mem_rd`=1, `addr`=0..N_SAMPLES-1. The counter wraps to 0 on leaving P1.
- `acc1_en` is `mem_rd` delayed one cycle, so it is high in P1 cycles 2..N and in P1_DRN.
- P1_DRN (1 cycle): drains the last read.
- MEAN_X, MEAN_Y, SLOPE (divide states):
  - `div_sel` = 0/1/2 respectively.
  - `div_start`=1 in the first cycle of the state only.
  - The state holds until `div_done`.
  - On `div_done`, `xm_ld`/`ym_ld`/`b1_ld` pulses in the same cycle, then the FSM advances.
- `div_done` is ignored:
  - in the `div_start` cycle;
  - in any non-divide state.
- P2/P2_DRN: identical to P1/P1_DRN with `acc2_en` in place of `acc1_en`.
- ICPT (1 cycle): `b0_ld`=1.
- DONE: `coeff_done`=1, held. `en`=1 → CLR, and `coeff_done` drops in that cycle.
- `en` while busy: ignored.
- `rst` asserted at any time: state IDLE, counter 0, all outputs 0 immediately (asynchronous). The next `en` starts a clean run.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `en` or `div_done` to any output except the load pulses on `div_done`.
- Latency definition: L = `div_done` delay after `div_start`, L ≥ 1. Each divide state lasts L+1 cycles.
- Cycles from the `en`-sampling edge to the first DONE cycle: 2·N_SAMPLES + 3·L + 7.
  - N_SAMPLES=150, L=1: 310.
- Reset values: `addr`=0, all 1-bit outputs 0, `div_sel`=0.

## Structure
- Shared package `lr_pkg`:
  - state enum;
  - `div_sel` codes DIV_XMEAN=0, DIV_YMEAN=1, DIV_SLOPE=2;
  - default N_SAMPLES/ADDR_W constants.
- One sub-module, `lr_sample_counter`:
  - ports: clr, inc, wrap-at-N_SAMPLES, `last` flag;
  - used for both passes.
- FSM and the `mem_rd`→`acc_en` delay register live in the top.

## Test plan
- Reset: assert `rst` mid-clock → all outputs 0, `addr`=0 without waiting for an edge.
- Full run, N_SAMPLES=4, L=1:
  - `addr` 0,1,2,3 twice;
  - `acc1_en`/`acc2_en` each high exactly 4 cycles, lagging `mem_rd` by 1;
  - `xm_ld`/`ym_ld`/`b1_ld`/`b0_ld` each pulse once, in that order;
  - `coeff_done` at cycle 18 after `en`.
- Divider latency L=5, N_SAMPLES=4: `div_start` 3 pulses, `div_sel` 0→1→2 stable through each divide, `coeff_done` at cycle 30.
- Start handling:
  - `en` held high during run → no restart;
  - `en` pulse in DONE → `coeff_done` drops, `acc_clr` pulses next cycle, second run identical.
- Reset during P2 at address 2 → IDLE, outputs 0. A following `en` yields a complete 18-cycle run (N_SAMPLES=4, L=1).
- Spurious `div_done`:
  - in P1 → no loads;
  - coincident with `div_start` → ignored, state waits for the next `div_done`.
